// File: rtl/ldpc_llr_buffer_if.sv
// Port bundle of the LDPC LLR input buffer: the LLR input stream, the
// codeword read port toward the decoder core, and the slot status/release lines.
interface ldpc_llr_buffer_if #(
  parameter int IN_WIDTH        = 8,
  parameter int LLR_WIDTH       = 6,
  parameter int CODEWORD_LENGTH = 2304,
  parameter int NUM_BUFS        = 4
);
  localparam int SLOT_W = $clog2(NUM_BUFS);
  localparam int ADDR_W = $clog2(CODEWORD_LENGTH);

  // Input stream: a beat transfers on a rising clock edge where i_in_valid
  // and o_in_ready are both high. o_in_ready never looks at i_in_valid, and a
  // producer keeps i_in_data/i_in_last stable while i_in_valid waits.
  logic signed [IN_WIDTH-1:0] i_in_data;
  logic                       i_in_last;
  logic                       i_in_valid;
  logic                       o_in_ready;

  logic                       o_frame_avail;
  logic [SLOT_W-1:0]          o_frame_slot;
  logic [SLOT_W:0]            o_level;

  logic [ADDR_W-1:0]          i_rd_addr;
  logic                       i_rd_valid;
  logic [LLR_WIDTH-1:0]       o_rd_data;
  logic                       o_rd_valid;

  logic                       i_release;
  logic                       o_frame_err;

  modport master (
    output i_in_data, i_in_last, i_in_valid, i_rd_addr, i_rd_valid, i_release,
    input  o_in_ready, o_frame_avail, o_frame_slot, o_level, o_rd_data, o_rd_valid,
           o_frame_err
  );

  modport slave (
    input  i_in_data, i_in_last, i_in_valid, i_rd_addr, i_rd_valid, i_release,
    output o_in_ready, o_frame_avail, o_frame_slot, o_level, o_rd_data, o_rd_valid,
           o_frame_err
  );
endinterface

// File: rtl/ldpc_llr_buffer.sv
// Multi-slot LLR codeword buffer: saturates incoming LLRs, packs them into
// NUM_BUFS codeword slots and serves the oldest committed slot to the decoder.
module ldpc_llr_buffer #(
  parameter int IN_WIDTH        = 8,
  parameter int LLR_WIDTH       = 6,
  parameter int CODEWORD_LENGTH = 2304,
  parameter int NUM_BUFS        = 4
) (
  input logic               i_clock,
  input logic               i_reset,
  ldpc_llr_buffer_if.slave  bus
);
  localparam int SLOT_W    = $clog2(NUM_BUFS);
  localparam int ADDR_W    = $clog2(CODEWORD_LENGTH);
  localparam int PTR_W     = SLOT_W + 1;
  localparam int RAM_DEPTH = NUM_BUFS << ADDR_W;

  localparam logic [ADDR_W-1:0] LAST_OFS = ADDR_W'(CODEWORD_LENGTH - 1);
  localparam logic [ADDR_W:0]   CW_LEN   = (ADDR_W + 1)'(CODEWORD_LENGTH);

  logic [PTR_W-1:0]     head_q;
  logic [PTR_W-1:0]     tail_q;
  logic [ADDR_W-1:0]    wr_cnt_q;
  logic                 frame_err_q;
  logic                 rd_valid_q;
  logic [LLR_WIDTH-1:0] rd_data_q;
  logic [LLR_WIDTH-1:0] sat_data;
  logic [LLR_WIDTH-1:0] mem [RAM_DEPTH];

  logic empty;
  logic full;
  logic in_ready;
  logic wr_fire;
  logic wr_at_end;
  logic rd_fire;
  logic rel_fire;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign empty     = (head_q == tail_q);
  assign full      = (head_q[SLOT_W] != tail_q[SLOT_W]) &&
                     (head_q[SLOT_W-1:0] == tail_q[SLOT_W-1:0]);
  assign in_ready  = !full && !i_reset;
  assign wr_fire   = bus.i_in_valid && in_ready;
  assign wr_at_end = (wr_cnt_q == LAST_OFS);
  assign rd_fire   = bus.i_rd_valid && !empty && ({1'b0, bus.i_rd_addr} < CW_LEN);
  assign rel_fire  = bus.i_release && !empty;

  generate
    if (LLR_WIDTH < IN_WIDTH) begin : g_sat
      // Symmetric clamp: the most negative input folds to -POS_LIM as well.
      localparam logic signed [IN_WIDTH-1:0] POS_LIM = IN_WIDTH'((2 ** (LLR_WIDTH - 1)) - 1);
      localparam logic signed [IN_WIDTH-1:0] NEG_LIM = -POS_LIM;
      always_comb begin
        sat_data = bus.i_in_data[LLR_WIDTH-1:0];
        if (bus.i_in_data > POS_LIM) begin
          sat_data = POS_LIM[LLR_WIDTH-1:0];
        end else if (bus.i_in_data < NEG_LIM) begin
          sat_data = NEG_LIM[LLR_WIDTH-1:0];
        end
      end
    end else begin : g_ext
      assign sat_data = LLR_WIDTH'(bus.i_in_data);
    end
  endgenerate

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      wr_cnt_q    <= '0;
      frame_err_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      frame_err_q <= 1'b0;
      if (wr_fire) begin
        if (wr_at_end) begin
          // A full-length frame always commits; a missing last only flags it.
          head_q      <= head_q + PTR_W'(1);
          wr_cnt_q    <= '0;
          frame_err_q <= !bus.i_in_last;
        end else if (bus.i_in_last) begin
          wr_cnt_q    <= '0;
          frame_err_q <= 1'b1;
        end else begin
          wr_cnt_q <= wr_cnt_q + ADDR_W'(1);
        end
      end
      if (rel_fire) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_data_q <= mem[{tail_q[SLOT_W-1:0], bus.i_rd_addr}];
      end
    end
  end

  // Storage array is never reset; only committed slots are ever read.
  always_ff @(posedge i_clock) begin
    if (wr_fire) begin
      mem[{head_q[SLOT_W-1:0], wr_cnt_q}] <= sat_data;
    end
  end

  assign bus.o_in_ready    = in_ready;
  assign bus.o_frame_avail = !empty;
  assign bus.o_frame_slot  = tail_q[SLOT_W-1:0];
  assign bus.o_level       = head_q - tail_q;
  assign bus.o_rd_data     = rd_data_q;
  assign bus.o_rd_valid    = rd_valid_q;
  assign bus.o_frame_err   = frame_err_q;
endmodule

// File: doc/ldpc_llr_buffer.md
# ldpc_llr_buffer

Parametrised multi-slot LLR input buffer in front of the LDPC decoder core. It accepts a ready/valid stream of signed channel LLRs and saturates each to the internal LLR width. It packs them into one of NUM_BUFS codeword slots and hands completed codewords to the decoder core in FIFO order. The core reads each codeword by random address and releases the slot when decoding finishes. It generalises the fixed two-slot, 8-bit LLR store with configurable slot count, LLR width, codeword length, saturation and frame-length checking.

## Interface
- IN_WIDTH, 8, signed input LLR width
- LLR_WIDTH, 6, signed stored LLR width (saturated)
- CODEWORD_LENGTH, 2304, LLRs per codeword
- NUM_BUFS, 4, codeword slots; power of two, ≥2
- i_clock  in  1  clock
- i_reset  in  1  reset: i_reset, synchronous, active-high; clock i_clock
- i_in_data  in  IN_WIDTH  signed LLR
- i_in_last  in  1  marks final LLR of a codeword
- i_in_valid  in  1  input beat valid
- o_in_ready  out  1  buffer can accept a beat
- o_frame_avail  out  1  at least one committed codeword is present
- o_frame_slot  out  clog2(NUM_BUFS)  slot index of the oldest committed codeword (tail)
- o_level  out  clog2(NUM_BUFS)+1  number of committed codewords
- i_rd_addr  in  clog2(CODEWORD_LENGTH)  LLR offset within the tail slot
- i_rd_valid  in  1  read request
- o_rd_data  out  LLR_WIDTH  read data
- o_rd_valid  out  1  read data valid
- i_release  in  1  frees the tail slot
- o_frame_err  out  1  one-cycle pulse on a framing error

## Operation
- State:
  - head and tail pointers, each clog2(NUM_BUFS)+1 bits.
  - Write offset counter wr_cnt, 0..CODEWORD_LENGTH-1.
- Pointer status:
  - Empty when head == tail.
  - Full when the MSBs differ and the LSBs are equal.
  - o_level = head − tail, computed modulo 2^(clog2(NUM_BUFS)+1).
- Handshake outputs:
  - o_in_ready = !full && !i_reset. It does not depend combinationally on i_in_valid.
  - o_frame_avail = !empty.
  - o_frame_slot = tail LSBs.
- Storage: inferred simple dual-port RAM, depth NUM_BUFS·2^clog2(CODEWORD_LENGTH), address {slot, offset}. RAM contents are not reset.
- Accepted beat (i_in_valid && o_in_ready): writes sat(i_in_data) to {head LSBs, wr_cnt}.
- Saturation:
  - If LLR_WIDTH < IN_WIDTH, clamp symmetrically to ±(2^(LLR_WIDTH−1)−1). The most negative input also maps to −(2^(LLR_WIDTH−1)−1).
  - Otherwise sign-extend.
- Commit: on an accepted beat with wr_cnt == CODEWORD_LENGTH−1, head increments and wr_cnt returns to 0.
- Missing last: if that commit beat lacks i_in_last, the codeword is still committed and o_frame_err pulses.
- Early last: an accepted beat with i_in_last and wr_cnt < CODEWORD_LENGTH−1 discards the partial frame. wr_cnt returns to 0, head is unchanged and o_frame_err pulses.
- Reads: a request is accepted when i_rd_valid && !empty && i_rd_addr < CODEWORD_LENGTH. It reads {tail LSBs, i_rd_addr}. Any other request is ignored and produces no o_rd_valid.
- Release: i_release with !empty increments tail. i_release while empty is ignored.
- Wrap-around: the pointers wrap naturally through the extra MSB, with no special case at NUM_BUFS.

## Timing
- Reset values:
  - head = tail = 0, wr_cnt = 0.
  - o_in_ready = 0 during reset and 1 on the first cycle after.
  - o_frame_avail = 0, o_level = 0, o_rd_valid = 0, o_frame_err = 0.
  - o_rd_data = 0, o_frame_slot = 0.
- Reset mid-frame discards all partial and committed data.
- Write to read: a committed codeword is readable on the cycle after its final beat. o_frame_avail and o_level update in that cycle.
- Read latency: exactly 1 cycle; o_rd_data and o_rd_valid are registered. Back-to-back reads sustain one per cycle.
- Read and release in the same cycle: the read uses the pre-release tail.
- Commit and release in the same cycle: both take effect and o_level is unchanged.
- Full: o_in_ready deasserts the cycle after the commit that fills the last slot. It reasserts the cycle after a release.
- o_frame_err asserts in the cycle after the offending beat, for exactly one cycle.

## Test plan
- NUM_BUFS=4, CODEWORD_LENGTH=16: stream 4 frames with correct last and no release -> o_level steps 1..4, o_in_ready=0 after the 64th beat, one release -> o_in_ready=1 next cycle.
- IN_WIDTH=8, LLR_WIDTH=6: inputs +100, −128, −31, +31, 0 -> read back +31, −31, −31, +31, 0, each one cycle after its request.
- i_in_last on beat 5 of a 16-LLR frame -> o_frame_err pulse, o_level stays 0, next 16-beat frame commits to slot 0.
- Frame of 16 beats without last -> frame committed, o_frame_err pulses once.
- Commit and release in the same cycle with level 2 -> level stays 2, o_frame_slot advances by 1. Read issued with that release returns the old slot's data.
- Reset asserted mid-frame with 2 committed frames -> all outputs return to reset values, o_in_ready=1 the cycle after reset drops.
